// File: rtl/elevator_ctrl_param_if.sv
// Car controller bus: call/door buttons in, car status out.
interface elevator_ctrl_param_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
);
  logic [FLOORS-1:0]  req;
  logic               inopen;
  logic               inclose;
  logic               open;
  logic               close;
  logic               up;
  logic               down;
  logic [FLOOR_W-1:0] y;
  logic [FLOORS-1:0]  pending;

  modport master (output req, inopen, inclose,
                  input  open, close, up, down, y, pending);
  modport slave  (input  req, inopen, inclose,
                  output open, close, up, down, y, pending);
endinterface

// File: rtl/elevator_ctrl_param.sv
// Single-car SCAN controller: latches floor calls, times travel and door dwell.
module elevator_ctrl_param #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 8
) (
  input logic clk,
  input logic rst,
  elevator_ctrl_param_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DOOR, MOVE_UP, MOVE_DOWN} state_t;
  typedef enum logic {DIR_DN, DIR_UP} dir_t;

  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = $clog2(DOOR_CYCLES);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP  = FLOOR_W'(FLOORS - 1);

  state_t             state, state_n;
  dir_t               dir, dir_n;
  logic [FLOOR_W-1:0] y, y_n;
  logic [FLOORS-1:0]  pending, pending_n, latch, arrive_clr;
  logic [MW-1:0]      mcnt, mcnt_n;
  logic [DW-1:0]      dcnt, dcnt_n;
  logic               above, below, here_req;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && i > int'(y)) above = 1'b1;
      if (pending[i] && i < int'(y)) below = 1'b1;
    end
  end

  assign here_req = bus.req[y];

  always_comb begin
    state_n    = state;
    dir_n      = dir;
    y_n        = y;
    mcnt_n     = mcnt;
    dcnt_n     = dcnt;
    latch      = bus.req;
    arrive_clr = '0;
    case (state)
      IDLE: begin
        // a call at the current landing is served by the door, not queued
        latch[y] = 1'b0;
        if (here_req || bus.inopen) begin
          state_n = DOOR;
          dcnt_n  = DOOR_LOAD;
        end else if (above && (dir == DIR_UP || !below)) begin
          state_n = MOVE_UP;
          dir_n   = DIR_UP;
          mcnt_n  = '0;
        end else if (below) begin
          state_n = MOVE_DOWN;
          dir_n   = DIR_DN;
          mcnt_n  = '0;
        end
      end
      DOOR: begin
        latch[y] = 1'b0;
        if (bus.inopen || here_req) begin
          dcnt_n = DOOR_LOAD;
        end else if (bus.inclose || dcnt == '0) begin
          state_n = IDLE;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dcnt - 1'b1;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (mcnt == MOVE_LAST) begin
          mcnt_n = '0;
          y_n    = (state == MOVE_UP) ? y + 1'b1 : y - 1'b1;
          // arrival clear beats a same-edge call for the new floor
          if (pending[y_n]) begin
            arrive_clr[y_n] = 1'b1;
            state_n         = DOOR;
            dcnt_n          = DOOR_LOAD;
          end else if (pending == '0 ||
                       (state == MOVE_UP   && y_n == TOP) ||
                       (state == MOVE_DOWN && y_n == '0)) begin
            state_n = IDLE;
          end
        end else begin
          mcnt_n = mcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    pending_n = (pending | latch) & ~arrive_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dir     <= DIR_UP;
      y       <= '0;
      pending <= '0;
      mcnt    <= '0;
      dcnt    <= '0;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      y       <= y_n;
      pending <= pending_n;
      mcnt    <= mcnt_n;
      dcnt    <= dcnt_n;
    end
  end

  assign bus.open    = (state == DOOR);
  assign bus.close   = (state != DOOR);
  assign bus.up      = (state == MOVE_UP);
  assign bus.down    = (state == MOVE_DOWN);
  assign bus.y       = y;
  assign bus.pending = pending;
endmodule

// File: tb/tb_elevator_ctrl_param.sv
// Directed bench; door-open events are scoreboarded against expected floors.
module tb_elevator_ctrl_param;
  localparam int FLOORS = 8;
  localparam int FW     = 3;

  logic clk = 1'b0;
  logic rst;

  elevator_ctrl_param_if #(.FLOORS(FLOORS), .FLOOR_W(FW)) bus ();

  elevator_ctrl_param #(.FLOORS(FLOORS), .FLOOR_W(FW), .MOVE_CYCLES(4), .DOOR_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  logic prev_open = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // each rising edge of open must match the next expected service floor
  always @(negedge clk) begin
    if (bus.open && !prev_open) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL open_unexpected: observed floor %0d expected no door event", bus.y);
      end else begin
        chk("open_floor", 64'(bus.y), 64'(exp_q.pop_front()));
      end
    end
    prev_open = bus.open;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int f);
    bus.req = '0;
    bus.req[f] = 1'b1;
    tick(1);
    bus.req = '0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int k = 0;
    while (!(bus.close && !bus.up && !bus.down && bus.pending == '0 && exp_q.size() == 0)
           && k < maxc) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(k < maxc), 64'd1);
  endtask

  task automatic wait_move(input string tag, input int f, input logic dn, input int maxc);
    int k = 0;
    while (!(int'(bus.y) == f && (dn ? bus.down : bus.up)) && k < maxc) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(k < maxc), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.inopen = 1'b0;
    bus.inclose = 1'b0;
    tick(2);
    rst = 1'b0;

    // 1: reset state, idle, then async reset mid-move
    chk("rst_y", 64'(bus.y), 64'd0);
    chk("rst_outs", 64'({bus.open, bus.close, bus.up, bus.down}), 64'b0100);
    tick(10);
    chk("idle_outs", 64'({bus.open, bus.close, bus.up, bus.down}), 64'b0100);
    chk("idle_pending", 64'(bus.pending), 64'd0);
    pulse(5);
    wait_move("reach_3_up", 3, 1'b0, 100);
    chk("mid_up", 64'(bus.up), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_y", 64'(bus.y), 64'd0);
    chk("async_outs", 64'({bus.open, bus.close, bus.up, bus.down}), 64'b0100);
    chk("async_pending", 64'(bus.pending), 64'd0);
    #2 rst = 1'b0;
    tick(1);

    // 2: call at current floor opens door for 8 cycles
    exp_q.push_back(0);
    bus.req = 8'h01;
    tick(1);
    bus.req = '0;
    chk("door0_open", 64'(bus.open), 64'd1);
    chk("door0_pending", 64'(bus.pending), 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chk("door0_hold", 64'(bus.open), 64'd1);
    end
    tick(1);
    chk("door0_close", 64'({bus.open, bus.close}), 64'b01);

    // 3: travel 0 -> 7, one floor per 4 cycles
    exp_q.push_back(7);
    pulse(7);
    chk("latch7", 64'(bus.pending), 64'h80);
    chk("latch7_up", 64'(bus.up), 64'd0);
    tick(1);
    chk("start_up", 64'({bus.up, bus.down}), 64'b10);
    chk("start_y", 64'(bus.y), 64'd0);
    for (int f = 1; f <= 7; f++) begin
      tick(4);
      chk("step_y", 64'(bus.y), 64'(f));
      if (f < 7) chk("step_up", 64'(bus.up), 64'd1);
    end
    chk("arrive7", 64'({bus.open, bus.up}), 64'b10);
    chk("arrive7_pend", 64'(bus.pending), 64'd0);
    tick(8);
    chk("arrive7_close", 64'(bus.close), 64'd1);

    // 4: SCAN ordering 5, 6 then reverse to 1
    exp_q.push_back(3);
    pulse(3);
    wait_done("go3", 200);
    exp_q.push_back(5);
    exp_q.push_back(6);
    exp_q.push_back(1);
    pulse(6);
    tick(1);
    chk("scan_up", 64'(bus.up), 64'd1);
    bus.req = 8'h22;
    tick(1);
    bus.req = '0;
    chk("scan_pend", 64'(bus.pending), 64'h62);
    wait_done("scan_done", 400);
    chk("scan_y", 64'(bus.y), 64'd1);

    // 5: door buttons at floor 2
    exp_q.push_back(2);
    pulse(2);
    begin
      int k = 0;
      while (!bus.open && k < 100) begin
        tick(1);
        k++;
      end
      chk("door2_reach", 64'(k < 100), 64'd1);
    end
    chk("door2_y", 64'(bus.y), 64'd2);
    bus.inopen = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("hold_open", 64'(bus.open), 64'd1);
    end
    bus.inopen = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chk("release_open", 64'(bus.open), 64'd1);
    end
    tick(1);
    chk("release_close", 64'(bus.close), 64'd1);
    exp_q.push_back(2);
    bus.inopen = 1'b1;
    tick(1);
    bus.inopen = 1'b0;
    chk("reopen", 64'(bus.open), 64'd1);
    bus.inclose = 1'b1;
    tick(1);
    bus.inclose = 1'b0;
    chk("inclose_close", 64'(bus.close), 64'd1);
    exp_q.push_back(2);
    bus.inopen = 1'b1;
    tick(1);
    bus.inclose = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("both_open", 64'(bus.open), 64'd1);
    end
    bus.inopen = 1'b0;
    bus.inclose = 1'b0;
    tick(8);
    chk("both_close", 64'(bus.close), 64'd1);
    chk("door_pend", 64'(bus.pending), 64'd0);

    // 6: call for the floor being left while moving down
    exp_q.push_back(7);
    pulse(7);
    wait_done("go7", 300);
    exp_q.push_back(0);
    exp_q.push_back(4);
    pulse(0);
    wait_move("reach_4_down", 4, 1'b1, 100);
    bus.req = 8'h10;
    tick(1);
    bus.req = '0;
    chk("leave4_latch", 64'(bus.pending[4]), 64'd1);
    wait_done("serve_0_4", 400);
    chk("final_y", 64'(bus.y), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/elevator_ctrl_param.md
Name: elevator_ctrl_param

Overview:
Parametrised car controller for a single elevator serving FLOORS landings. It latches floor requests into a pending vector and schedules them with SCAN: keep travelling in the current direction while requests remain ahead, then reverse. It times floor-to-floor travel and door dwell, and honours door-open/door-close buttons. It replaces the fixed 8-floor controller as the top-level car FSM.

Parameters:
FLOORS, 8, number of landings (2..64); floor 0 is ground.
FLOOR_W, 3, width of floor index; must satisfy 2**FLOOR_W >= FLOORS.
MOVE_CYCLES, 4, clock cycles to travel one floor (>=1).
DOOR_CYCLES, 8, clock cycles door stays open per dwell (>=2).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; asynchronous, active-high.
req  input  FLOORS  floor call buttons, one bit per floor; sampled every cycle, pulse or level.
inopen  input  1  door-open button.
inclose  input  1  door-close button.
open  output  1  door open.
close  output  1  door closed; always the complement of open.
up  output  1  car moving up.
down  output  1  car moving down.
y  output  FLOOR_W  current floor index.
pending  output  FLOORS  latched outstanding requests.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: y=0, pending=0, open=0, close=1, up=0, down=0. FSM goes to IDLE, dir=UP, both timers=0.
- Reset asserted mid-move or mid-dwell takes effect immediately, without waiting for a clock edge.
- FSM states: IDLE, DOOR, MOVE_UP, MOVE_DOWN.
- Outputs by state: open=1 only in DOOR; up=1 only in MOVE_UP; down=1 only in MOVE_DOWN. up and down are never both 1.
- Request latch: at each edge, pending |= req, with one exception.
  - In IDLE or DOOR, req[y] is not latched. Instead it opens the door (from IDLE) or reloads the door timer (in DOOR).
  - While moving, req[y] is latched, because the car is leaving y.
- IDLE:
  - req[y] or inopen: go to DOOR, door timer = DOOR_CYCLES-1.
  - Else, if any pending above y and (dir=UP or none pending below y): go to MOVE_UP, dir=UP.
  - Else, if any pending below y: go to MOVE_DOWN, dir=DOWN.
  - Else stay in IDLE.
  - The decision uses pending as registered. A new request therefore starts motion 2 edges after req is asserted.
- MOVE_UP / MOVE_DOWN:
  - Move counter runs 0..MOVE_CYCLES-1. On terminal count, y increments or decrements by 1 and the counter clears.
  - If pending[new y] is set: clear it and go to DOOR with timer = DOOR_CYCLES-1.
  - Otherwise continue in the same direction.
  - If pending is emptied by reset only, the next state is IDLE.
- Floor limits: y never exceeds FLOORS-1 and never goes below 0. MOVE_UP is never entered at FLOORS-1, and MOVE_DOWN is never entered at 0.
- DOOR:
  - Timer decrements each cycle.
  - inopen reloads the timer to DOOR_CYCLES-1.
  - Else inclose forces timer to 0.
  - When the timer is 0 and inopen=0: go to IDLE (close=1). SCAN re-evaluates on the following edge.
  - inopen has priority over inclose when both are asserted.
- Simultaneous events:
  - An arrival clear of pending[y] and req[y] on the same edge: the clear wins (the request is served).
  - Requests for other floors arriving during the arrival edge are latched normally.
- Width rule: req bits map 1:1 to floors. The y arithmetic is FLOOR_W bits and never wraps, by the floor-limit rule above.

Test Plan:
(Defaults FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=8.)
1. Reset, then idle 10 cycles -> y=0, close=1, open=up=down=0, pending=0. Assert rst mid-MOVE_UP at y=3 -> outputs return to reset values immediately, before the next edge.
2. IDLE at y=0, 1-cycle pulse req[0] -> open=1 from the next edge for exactly 8 cycles, then close=1. pending stays 0.
3. IDLE at y=0, pulse req[7] -> pending[7]=1 next edge; up=1 one edge later; y steps 1..7, one step every 4 cycles; at y=7, up=0, open=1, pending[7]=0.
4. SCAN: car moving up from y=3 to a request at 6; pulse req[1] and req[5] -> stops at 5 (door 8 cycles), then 6, then reverses with down=1 and stops at 1. The order of open events is 5, 6, 1.
5. In DOOR at y=2: hold inopen 20 cycles -> open stays 1 throughout, then closes 8 cycles after release. Pulse inclose alone -> close=1 on the following edge. inopen and inclose together -> open stays 1.
6. Pulse req[4] while at y=4 in MOVE_DOWN toward 0 -> pending[4]=1. Car serves 0 first, then moves up and opens at 4.
